// File: rtl/mem_alu_engine_pkg.sv
// Shared opcodes, FSM state encoding and instruction-width helper for the
// memory/ALU engine.
package mem_alu_pkg;

    localparam logic [3:0] OP_LDI = 4'd0;
    localparam logic [3:0] OP_EQ  = 4'd1;
    localparam logic [3:0] OP_LT  = 4'd2;
    localparam logic [3:0] OP_LE  = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MAX = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;
    localparam logic [3:0] OP_ADD = 4'd11;
    localparam logic [3:0] OP_SUB = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;
    localparam logic [3:0] OP_MOD = 4'd15;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    function automatic int instr_w(input int addr_w);
        return 4 + 3 * addr_w;
    endfunction

endpackage

// File: rtl/mem_alu_engine_exec.sv
// Combinational ALU: computes the result word and carry/divide-by-zero flags
// from the latched opcode and the two operand registers.
module mem_alu_exec
    import mem_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic [3:0]          opc,
    input  logic [DATA_W-1:0]   r1,
    input  logic [DATA_W-1:0]   r2,
    input  logic [2*ADDR_W-1:0] imm,
    output logic [DATA_W-1:0]   r3,
    output logic                carry,
    output logic                div_zero
);

    logic [DATA_W:0]              sum;
    logic [DATA_W+2*ADDR_W-1:0]   imm_ext;
    logic                         big_shift;
    logic                         r2_zero;

    assign sum       = {1'b0, r1} + {1'b0, r2};
    assign imm_ext   = {{DATA_W{1'b0}}, imm};
    assign big_shift = (r2 >= DATA_W'(DATA_W));
    assign r2_zero   = (r2 == '0);

    always_comb begin
        r3       = '0;
        carry    = 1'b0;
        div_zero = 1'b0;
        case (opc)
            OP_LDI: r3 = imm_ext[DATA_W-1:0];
            OP_EQ:  r3 = {{(DATA_W-1){1'b0}}, (r1 == r2)};
            OP_LT:  r3 = {{(DATA_W-1){1'b0}}, (r1 < r2)};
            OP_LE:  r3 = {{(DATA_W-1){1'b0}}, (r1 <= r2)};
            OP_OR:  r3 = r1 | r2;
            OP_SHL: r3 = big_shift ? '0 : (r1 << r2);
            OP_SHR: r3 = big_shift ? '0 : (r1 >> r2);
            OP_MAX: r3 = (r1 >= r2) ? r1 : r2;
            OP_AND: r3 = r1 & r2;
            OP_XOR: r3 = r1 ^ r2;
            OP_NOT: r3 = ~r1;
            OP_ADD: begin
                r3    = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                r3    = r1 - r2;
                carry = (r1 < r2);
            end
            OP_MUL: r3 = r1 * r2;
            OP_DIV: begin
                div_zero = r2_zero;
                r3       = r2_zero ? '1 : (r1 / r2);
            end
            OP_MOD: begin
                div_zero = r2_zero;
                r3       = r2_zero ? r1 : (r1 % r2);
            end
            default: r3 = '0;
        endcase
    end

endmodule

// File: rtl/mem_alu_engine.sv
// Three-address instruction engine: handshake, four-state sequencer, register
// file memory and registered debug read port.
//
// state | meaning
// IDLE  | instr_ready high; latch instruction on instr_valid
// READ  | r1 <= mem[a], r2 <= mem[b]
// EXEC  | r3 and flags from the ALU
// WRITE | mem[d] <= r3, result <= r3; done pulses next cycle
module mem_alu_engine
    import mem_alu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 4,
    localparam int INSTR_W = instr_w(ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic               div_zero,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [DATA_W-1:0]  r1,
    output logic [DATA_W-1:0]  r2,
    output logic [DATA_W-1:0]  r3
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t               state, state_nx;
    logic [INSTR_W-1:0]   instr_q;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [3:0]           opc_f;
    logic [ADDR_W-1:0]    a_f, b_f, d_f;
    logic [DATA_W-1:0]    ex_r3;
    logic                 ex_carry, ex_dz;

    assign opc_f = instr_q[INSTR_W-1 -: 4];
    assign a_f   = instr_q[3*ADDR_W-1 -: ADDR_W];
    assign b_f   = instr_q[2*ADDR_W-1 -: ADDR_W];
    assign d_f   = instr_q[ADDR_W-1:0];

    assign instr_ready = (state == IDLE);

    mem_alu_exec #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exec (
        .opc      (opc_f),
        .r1       (r1),
        .r2       (r2),
        .imm      ({a_f, b_f}),
        .r3       (ex_r3),
        .carry    (ex_carry),
        .div_zero (ex_dz)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (instr_valid) state_nx = READ;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            result   <= '0;
            carry    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            dbg_data <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done     <= (state == WRITE);
            // Nonblocking read gives the pre-write value when WRITE hits dbg_addr.
            dbg_data <= mem[dbg_addr];
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                READ: begin
                    r1 <= mem[a_f];
                    r2 <= mem[b_f];
                end
                EXEC: begin
                    r3    <= ex_r3;
                    carry <= ex_carry;
                    // div_zero reflects the last DIV/MOD only, so other opcodes hold it.
                    if (opc_f == OP_DIV || opc_f == OP_MOD) div_zero <= ex_dz;
                end
                WRITE: begin
                    mem[d_f] <= r3;
                    result   <= r3;
                end
                default: ;
            endcase
        end
    end

endmodule
